// File: rtl/rf_wb_queue.sv
`default_nettype none
// ============================================================================
//  Module      : rf_wb_queue
//  Description : Register-file writeback queue. Merges ALU and load results
//                into a circular FIFO, with the load source taking priority.
//                The head entry is retired to the register-file write port
//                every cycle the queue is occupied. Also provides
//                pending-write hazard queries and a conflict flag for
//                same-register, same-cycle offers.
//  Revision    : 1.0 - initial release
// ============================================================================
module rf_wb_queue #(
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       alu_valid,
   input  logic [2:0]                 alu_reg,
   input  logic [15:0]                alu_data,
   output logic                       alu_ready,
   input  logic                       mem_valid,
   input  logic [2:0]                 mem_reg,
   input  logic [15:0]                mem_data,
   output logic                       mem_ready,
   output logic                       write,
   output logic [2:0]                 writeregsel,
   output logic [15:0]                writedata,
   input  logic [2:0]                 q1sel,
   input  logic [2:0]                 q2sel,
   output logic                       q1pend,
   output logic                       q2pend,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       err
);

   localparam int             AW         = $clog2(DEPTH);
   localparam logic [AW:0]    FULL_COUNT = (AW+1)'(DEPTH);

   logic [2:0]    q_reg  [DEPTH];
   logic [15:0]   q_data [DEPTH];
   logic [AW-1:0] head;
   logic [AW-1:0] tail;
   logic          full;
   logic          enq;
   logic          deq;
   logic [2:0]    enq_reg;
   logic [15:0]   enq_data;
   logic [DEPTH-1:0] occupied;

   assign full      = (count == FULL_COUNT);
   assign mem_ready = mem_valid & ~full;
   assign alu_ready = alu_valid & ~full & ~mem_valid;
   assign enq       = mem_ready | alu_ready;
   assign enq_reg   = mem_valid ? mem_reg  : alu_reg;
   assign enq_data  = mem_valid ? mem_data : alu_data;

   // The register file always accepts the write, so an occupied head retires every cycle.
   assign deq         = (count != '0);
   assign write       = deq;
   assign writeregsel = deq ? q_reg[head]  : 3'd0;
   assign writedata   = deq ? q_data[head] : 16'd0;

   // An entry is live when its distance from head (modulo DEPTH) is below count.
   generate
      for (genvar i = 0; i < DEPTH; i++) begin : g_occ
         assign occupied[i] = ({1'b0, AW'(i) - head} < count);
      end
   endgenerate

   // Hazard queries: any live entry, head included, targeting the queried register.
   always_comb begin
      q1pend = 1'b0;
      q2pend = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (occupied[i] && (q_reg[i] == q1sel)) q1pend = 1'b1;
         if (occupied[i] && (q_reg[i] == q2sel)) q2pend = 1'b1;
      end
   end

   // Entry storage; contents are don't-care while unoccupied, so no reset is needed.
   always_ff @(posedge clk) begin
      if (enq) begin
         q_reg[tail]  <= enq_reg;
         q_data[tail] <= enq_data;
      end
   end

   // Pointer, occupancy and conflict-flag state.
   always_ff @(posedge clk) begin
      if (rst) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         err   <= 1'b0;
      end else begin
         if (enq) tail <= tail + 1'b1;
         if (deq) head <= head + 1'b1;
         case ({enq, deq})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         err <= alu_valid & mem_valid & (alu_reg == mem_reg);
      end
   end

endmodule
`default_nettype wire
